// File: rtl/ahbl_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_copy_master
// Purpose  : AHB-Lite initiator that copies a block of 32-bit words from a
//            source address range to a destination address range on the same
//            bus. Each word is moved with one SINGLE read followed by one
//            SINGLE write, so exactly one transfer is outstanding at a time.
//            Usable as a boot-time RAM loader, a RAM-to-RAM mover, or a
//            stimulus driver for AHB-Lite memory slaves.
//
// Ports    :
//   HCLK        in   clock, all logic on the rising edge
//   HRESET      in   synchronous active-high reset
//   start       in   one-cycle pulse, accepted only while idle
//   src         in   source byte address (bits [1:0] cleared on capture)
//   dst         in   destination byte address (bits [1:0] cleared on capture)
//   len         in   number of words to copy (0 = finish without bus traffic)
//   busy        out  high from the cycle after an accepted start up to and
//                    including the done cycle
//   done        out  one-cycle pulse at the end of a transfer (normal/aborted)
//   err         out  sticky error flag, cleared by the next accepted start
//   words_done  out  number of words fully written
//   HADDR..HWDATA    AHB-Lite master outputs (all registered)
//   HREADY      in   transfer ready from the slave multiplexor
//   HRDATA      in   read data
//   HRESP       in   slave error response
//
// Revision : 1.0  initial release
// ============================================================================
module ahbl_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA,
  input  logic             HRESP
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]  c_trans_idle   = 2'b00;
  localparam logic [1:0]  c_trans_nonseq = 2'b10;
  localparam logic [2:0]  c_size_word    = 3'b010;
  localparam logic [2:0]  c_burst_single = 3'b000;
  // Data access, privileged, non-bufferable, non-cacheable.
  localparam logic [3:0]  c_prot_data    = 4'b0011;
  localparam logic [31:0] c_word_mask    = 32'hFFFF_FFFC;
  localparam logic [31:0] c_word_bytes   = 32'd4;
  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

  // --------------------------------------------------------------------------
  // State encoding
  //   IDLE : waiting for start
  //   RA   : read address phase   RD : read data phase
  //   WA   : write address phase  WD : write data phase
  //   FIN  : one-cycle done pulse
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RA   = 3'd1,
    ST_RD   = 3'd2,
    ST_WA   = 3'd3,
    ST_WD   = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  state_t           r_state;

  // Bus-facing registers
  logic [31:0]      r_haddr;
  logic [1:0]       r_htrans;
  logic             r_hwrite;
  logic [31:0]      r_hwdata;

  // Status registers
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [LEN_W-1:0] r_words_done;

  // Transfer bookkeeping
  logic [31:0]      r_src_cur;
  logic [31:0]      r_dst_cur;
  logic [LEN_W-1:0] r_remaining;
  logic [31:0]      r_buf;

  // Word-aligned views of the start arguments; masking rather than slicing
  // keeps the full input vectors in use.
  logic [31:0]      w_src_aligned;
  logic [31:0]      w_dst_aligned;
  // Post-increment pointers, wrapping modulo 2^32 without any error.
  logic [31:0]      w_src_next;
  logic [31:0]      w_dst_next;
  logic             w_last_word;

  assign w_src_aligned = src & c_word_mask;
  assign w_dst_aligned = dst & c_word_mask;
  assign w_src_next    = r_src_cur + c_word_bytes;
  assign w_dst_next    = r_dst_cur + c_word_bytes;
  assign w_last_word   = (r_remaining == c_len_one);

  // --------------------------------------------------------------------------
  // Controller. All bus outputs are registered, so each state's bus values
  // are loaded on the edge that enters the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= ST_IDLE;
      r_haddr      <= 32'h0;
      r_htrans     <= c_trans_idle;
      r_hwrite     <= 1'b0;
      r_hwdata     <= 32'h0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_words_done <= '0;
      r_src_cur    <= 32'h0;
      r_dst_cur    <= 32'h0;
      r_remaining  <= '0;
      r_buf        <= 32'h0;
    end else begin
      // done is a single-cycle pulse; only the edge entering FIN raises it.
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src_cur    <= w_src_aligned;
            r_dst_cur    <= w_dst_aligned;
            r_remaining  <= len;
            r_err        <= 1'b0;
            r_words_done <= '0;
            r_busy       <= 1'b1;
            if (len == '0) begin
              // Nothing to move: report completion without touching the bus.
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_RA;
              r_htrans <= c_trans_nonseq;
              r_hwrite <= 1'b0;
              r_haddr  <= w_src_aligned;
            end
          end
        end

        ST_RA: begin
          // Address phase is held until the bus accepts it.
          if (HREADY) begin
            r_state  <= ST_RD;
            r_htrans <= c_trans_idle;
          end
        end

        ST_RD: begin
          // An ERROR response is acted on only in its completing cycle.
          if (HREADY) begin
            if (HRESP) begin
              r_err   <= 1'b1;
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_buf    <= HRDATA;
              r_state  <= ST_WA;
              r_htrans <= c_trans_nonseq;
              r_hwrite <= 1'b1;
              r_haddr  <= r_dst_cur;
            end
          end
        end

        ST_WA: begin
          if (HREADY) begin
            r_state  <= ST_WD;
            r_htrans <= c_trans_idle;
            // Write data goes out for the whole data phase that follows.
            r_hwdata <= r_buf;
          end
        end

        ST_WD: begin
          if (HREADY) begin
            if (HRESP) begin
              // Failed write: the word is not counted and pointers stay put.
              r_err   <= 1'b1;
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_words_done <= r_words_done + c_len_one;
              r_src_cur    <= w_src_next;
              r_dst_cur    <= w_dst_next;
              r_remaining  <= r_remaining - c_len_one;
              if (w_last_word) begin
                r_state <= ST_FIN;
                r_done  <= 1'b1;
              end else begin
                r_state  <= ST_RA;
                r_htrans <= c_trans_nonseq;
                r_hwrite <= 1'b0;
                r_haddr  <= w_src_next;
              end
            end
          end
        end

        ST_FIN: begin
          // busy covers the done cycle and drops on the way back to idle.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_htrans <= c_trans_idle;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign words_done = r_words_done;

  assign HADDR      = r_haddr;
  assign HTRANS     = r_htrans;
  assign HWRITE     = r_hwrite;
  assign HWDATA     = r_hwdata;
  assign HSIZE      = c_size_word;
  assign HBURST     = c_burst_single;
  assign HPROT      = c_prot_data;
  assign HMASTLOCK  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahbl_copy_master
// Purpose  : Self-checking bench for ahbl_copy_master. A small AHB-Lite slave
//            model (64-word memory, programmable wait states, two-cycle ERROR
//            on a chosen write) serves the copy master. Directed vectors are
//            kept in a table of {arguments, expected results}; reset and the
//            mid-transfer reset are handled by hand-written sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahbl_copy_master;

  logic        HCLK;
  logic        HRESET;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_done;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  ahbl_copy_master #(.LEN_W(16)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HPROT      (HPROT),
    .HMASTLOCK  (HMASTLOCK),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA),
    .HRESP      (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // --------------------------------------------------------------------------
  // Slave model
  // --------------------------------------------------------------------------
  logic [31:0] mem      [0:63];
  logic [31:0] init_mem [0:63];
  logic        mem_load;
  logic        dp_active, dp_write, dp_err, err_phase;
  logic [31:0] dp_addr;
  int          wait_cnt, wr_count, cfg_waits, err_target;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    if (dp_active) begin
      if (wait_cnt > 0) HREADY = 1'b0;
      else if (dp_err) begin
        HREADY = err_phase;
        HRESP  = 1'b1;
      end
      if (!dp_write) HRDATA = mem[dp_addr[7:2]];
    end
  end

  always @(posedge HCLK) begin
    if (mem_load)
      for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
    if (HRESET) begin
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_err    <= 1'b0;
      err_phase <= 1'b0;
      dp_addr   <= 32'h0;
      wait_cnt  <= 0;
      wr_count  <= 0;
    end else begin
      if (dp_active) begin
        if (wait_cnt > 0) wait_cnt <= wait_cnt - 1;
        else if (dp_err && !err_phase) err_phase <= 1'b1;
        else begin
          if (dp_write && !dp_err) mem[dp_addr[7:2]] <= HWDATA;
          dp_active <= 1'b0;
        end
      end
      if (HREADY && HTRANS == 2'b10) begin
        dp_active <= 1'b1;
        dp_addr   <= HADDR;
        dp_write  <= HWRITE;
        wait_cnt  <= cfg_waits;
        dp_err    <= HWRITE && (wr_count == err_target);
        err_phase <= 1'b0;
        if (HWRITE) wr_count <= wr_count + 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          waits;
    int          err_idx;   // write index that gets ERROR, -1 for none
    int          mid_cyc;   // cycle of an extra start pulse, 0 for none
    logic [31:0] mid_src;
    int          exp_done;  // cycle in which done is high (start edge = 0)
    int          exp_words;
    logic        exp_err;
    int          exp_ns;    // accepted NONSEQ transfers
  } vec_t;

  vec_t vecs [0:7];

  // Per-run observations
  logic [31:0] rd_addrs [$];
  logic [31:0] wr_addrs [$];
  int          ns_cnt, hold_bad, busy_bad, done_cyc;
  logic        post_busy, post_done;

  task automatic run_copy(input vec_t v);
    logic [31:0] p_haddr, p_hwdata;
    logic [1:0]  p_htrans;
    logic        p_hwrite, p_hready;
    cfg_waits  = v.waits;
    err_target = (v.err_idx < 0) ? -1 : wr_count + v.err_idx;
    rd_addrs.delete();
    wr_addrs.delete();
    ns_cnt = 0; hold_bad = 0; busy_bad = 0; done_cyc = -1;
    p_hready = 1'b1; p_haddr = 32'h0; p_hwdata = 32'h0; p_htrans = 2'b00; p_hwrite = 1'b0;
    @(negedge HCLK);
    start = 1'b1; src = v.src; dst = v.dst; len = v.len;
    for (int k = 1; k <= 300; k++) begin
      @(negedge HCLK);
      start = (k == v.mid_cyc);
      if (k == v.mid_cyc) begin
        src = v.mid_src;
        len = 16'd1;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        ns_cnt++;
        if (HWRITE) wr_addrs.push_back(HADDR);
        else        rd_addrs.push_back(HADDR);
      end
      if (!p_hready && (HADDR !== p_haddr || HTRANS !== p_htrans ||
                        HWRITE !== p_hwrite || HWDATA !== p_hwdata))
        hold_bad++;
      if (busy !== 1'b1) busy_bad++;
      p_hready = HREADY; p_haddr = HADDR; p_htrans = HTRANS;
      p_hwrite = HWRITE; p_hwdata = HWDATA;
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
    start = 1'b0;
    @(negedge HCLK);
    post_busy = busy;
    post_done = done;
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    int bad;
    int ndone;
    int nns;

    start = 1'b0; src = 32'h0; dst = 32'h0; len = 16'h0;
    HRESET = 1'b1; mem_load = 1'b1; cfg_waits = 0; err_target = -1;
    for (int i = 0; i < 64; i++) init_mem[i] = 32'hA000_0000 + 32'(i);
    init_mem[4] = 32'h11; init_mem[5] = 32'h22; init_mem[6] = 32'h33; init_mem[7] = 32'h44;

    //               src           dst           len waits err mid mid_src      done words err ns
    vecs[0] = '{32'h0000_0010, 32'h0000_0080, 16'd4, 0, -1, 0, 32'h0,         17, 4, 1'b0, 8};
    vecs[1] = '{32'h0000_0010, 32'h0000_00A0, 16'd2, 2, -1, 0, 32'h0,         17, 2, 1'b0, 4};
    vecs[2] = '{32'h0000_0010, 32'h0000_00B0, 16'd2, 1, -1, 0, 32'h0,         13, 2, 1'b0, 4};
    vecs[3] = '{32'h0000_0020, 32'h0000_00D0, 16'd3, 0,  1, 0, 32'h0,         10, 1, 1'b1, 4};
    vecs[4] = '{32'h0000_0010, 32'h0000_0080, 16'd0, 0, -1, 0, 32'h0,          1, 0, 1'b0, 0};
    vecs[5] = '{32'h0000_0010, 32'h0000_00E0, 16'd2, 0, -1, 3, 32'h0000_0020,  9, 2, 1'b0, 4};
    vecs[6] = '{32'hFFFF_FFF8, 32'h0000_0040, 16'd3, 0, -1, 0, 32'h0,         13, 3, 1'b0, 6};
    vecs[7] = '{32'h0000_0013, 32'h0000_00C3, 16'd1, 0, -1, 0, 32'h0,          5, 1, 1'b0, 2};

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("reset HTRANS",     32'(HTRANS), 32'h0);
    chk("reset HADDR",      HADDR, 32'h0);
    chk("reset HWRITE",     32'(HWRITE), 32'h0);
    chk("reset HWDATA",     HWDATA, 32'h0);
    chk("reset busy",       32'(busy), 32'h0);
    chk("reset done",       32'(done), 32'h0);
    chk("reset err",        32'(err), 32'h0);
    chk("reset words_done", 32'(words_done), 32'h0);
    chk("HSIZE",            32'(HSIZE), 32'h2);
    chk("HBURST",           32'(HBURST), 32'h0);
    chk("HPROT",            32'(HPROT), 32'h3);
    chk("HMASTLOCK",        32'(HMASTLOCK), 32'h0);
    HRESET = 1'b0;
    mem_load = 1'b0;

    for (int t = 0; t < 8; t++) begin
      run_copy(vecs[t]);
      chk($sformatf("v%0d done cycle", t), 32'(done_cyc), 32'(vecs[t].exp_done));
      chk($sformatf("v%0d words_done", t), 32'(words_done), 32'(vecs[t].exp_words));
      chk($sformatf("v%0d err", t), 32'(err), 32'(vecs[t].exp_err));
      chk($sformatf("v%0d nonseq count", t), 32'(ns_cnt), 32'(vecs[t].exp_ns));
      chk($sformatf("v%0d held during wait", t), 32'(hold_bad), 32'h0);
      chk($sformatf("v%0d busy low in transfer", t), 32'(busy_bad), 32'h0);
      chk($sformatf("v%0d busy after done", t), 32'(post_busy), 32'h0);
      chk($sformatf("v%0d done single pulse", t), 32'(post_done), 32'h0);
      bad = 0;
      foreach (rd_addrs[i])
        if (rd_addrs[i] !== (vecs[t].src & 32'hFFFF_FFFC) + 32'(4 * i)) bad++;
      chk($sformatf("v%0d read addr errors", t), 32'(bad), 32'h0);
      bad = 0;
      foreach (wr_addrs[i])
        if (wr_addrs[i] !== (vecs[t].dst & 32'hFFFF_FFFC) + 32'(4 * i)) bad++;
      chk($sformatf("v%0d write addr errors", t), 32'(bad), 32'h0);
      for (int i = 0; i < vecs[t].exp_words; i++)
        chk($sformatf("v%0d data word %0d", t, i),
            mem[6'(vecs[t].dst[7:2] + 6'(i))], init_mem[6'(vecs[t].src[7:2] + 6'(i))]);
    end

    // The failed second write of the error vector must leave memory untouched.
    chk("error word not written", mem[53], init_mem[53]);
    // Wrapped read addresses, spelled out.
    run_copy(vecs[6]);
    chk("wrap raddr0", (rd_addrs.size() > 0) ? rd_addrs[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    chk("wrap raddr1", (rd_addrs.size() > 1) ? rd_addrs[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap raddr2", (rd_addrs.size() > 2) ? rd_addrs[2] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Reset during the second write data phase while the slave is stalling.
    cfg_waits = 2; err_target = -1;
    @(negedge HCLK);
    start = 1'b1; src = 32'h10; dst = 32'hF0; len = 16'd2;
    for (int k = 1; k <= 14; k++) begin
      @(negedge HCLK);
      start = 1'b0;
      if (k == 14) begin
        chk("rstmid words_done before", 32'(words_done), 32'h1);
        chk("rstmid HREADY low", 32'(HREADY), 32'h0);
        chk("rstmid in write data phase", 32'({HWRITE, HTRANS}), 32'h4);
        HRESET = 1'b1;
      end
    end
    @(negedge HCLK);
    chk("rstmid HTRANS", 32'(HTRANS), 32'h0);
    chk("rstmid busy", 32'(busy), 32'h0);
    chk("rstmid words_done", 32'(words_done), 32'h0);
    chk("rstmid done", 32'(done), 32'h0);
    HRESET = 1'b0;
    ndone = 0; nns = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      if (done === 1'b1) ndone++;
      if (HTRANS !== 2'b00) nns++;
    end
    chk("rstmid no done pulse", 32'(ndone), 32'h0);
    chk("rstmid bus idle", 32'(nns), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
